// File: rtl/bicubic_window_feeder.sv
// Raster-to-window front end: three rotating line buffers feed four vertically
// aligned rows per accepted pixel, plus window/coordinate/frame status.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a checked SOF; non-SOF pixels are discarded
// FILL   | frame active, line < 3 (window not yet fully populated)
// RUN    | frame active, line >= 3
// DONE   | single bubble cycle after the last pixel, s_ready low
module bicubic_window_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   cfg_width,
  input  logic [15:0]           cfg_height,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0] row0_out,
  output logic [DATA_WIDTH-1:0] row1_out,
  output logic [DATA_WIDTH-1:0] row2_out,
  output logic [DATA_WIDTH-1:0] row3_out,
  output logic                  shift_window,
  output logic                  win_valid,
  output logic [ADDR_WIDTH-1:0] win_x,
  output logic [15:0]           win_y,
  output logic                  frame_done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef logic [ADDR_WIDTH:0] wid_t;

  localparam wid_t LP_MIN_W = wid_t'(4);
  localparam wid_t LP_MAX_W = wid_t'(MAX_WIDTH);

  state_t                r_state;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [15:0]           r_line;
  logic [1:0]            r_ptr;
  wid_t                  r_width;
  logic [15:0]           r_height;

  logic [DATA_WIDTH-1:0] r_row0;
  logic [DATA_WIDTH-1:0] r_rd1;
  logic [DATA_WIDTH-1:0] r_rd2;
  logic [DATA_WIDTH-1:0] r_rd3;
  logic                  r_m1;
  logic                  r_m2;
  logic                  r_m3;
  logic                  r_shift;
  logic                  r_winv;
  logic [ADDR_WIDTH-1:0] r_winx;
  logic [15:0]           r_winy;
  logic                  r_fdone;
  logic                  r_cerr;

  logic [DATA_WIDTH-1:0] r_bank0 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] r_bank1 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] r_bank2 [MAX_WIDTH];

  logic                  w_accept;
  logic                  w_sof_acc;
  logic                  w_geom_ok;
  logic                  w_start;
  logic                  w_reject;
  logic                  w_active;
  logic                  w_proc;
  logic [ADDR_WIDTH-1:0] w_col;
  logic [15:0]           w_line;
  logic [1:0]            w_ptr;
  logic [1:0]            w_ptr_nxt;
  wid_t                  w_wid;
  wid_t                  w_wid_m1;
  logic [15:0]           w_hgt;
  logic                  w_eol;
  logic                  w_eof;
  logic [DATA_WIDTH-1:0] w_b0;
  logic [DATA_WIDTH-1:0] w_b1;
  logic [DATA_WIDTH-1:0] w_b2;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic [DATA_WIDTH-1:0] w_rd3;

  assign w_accept  = s_valid & r_ready;
  assign w_sof_acc = w_accept & s_sof;
  assign w_geom_ok = (cfg_width >= LP_MIN_W) && (cfg_width <= LP_MAX_W) &&
                     (cfg_height >= 16'd4);
  assign w_start   = w_sof_acc & w_geom_ok;
  assign w_reject  = w_sof_acc & ~w_geom_ok;
  assign w_active  = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_proc    = w_start | (w_accept & ~s_sof & w_active);

  // A good SOF is processed as pixel (0,0) of the new geometry in the same cycle.
  assign w_col     = w_start ? '0 : r_col;
  assign w_line    = w_start ? '0 : r_line;
  assign w_ptr     = w_start ? 2'd0 : r_ptr;
  assign w_wid     = w_start ? cfg_width : r_width;
  assign w_hgt     = w_start ? cfg_height : r_height;
  assign w_wid_m1  = w_wid - wid_t'(1);
  assign w_eol     = ({1'b0, w_col} == w_wid_m1);
  assign w_eof     = w_eol && (w_line == (w_hgt - 16'd1));
  assign w_ptr_nxt = (w_ptr == 2'd2) ? 2'd0 : w_ptr + 2'd1;

  assign w_b0 = r_bank0[w_col];
  assign w_b1 = r_bank1[w_col];
  assign w_b2 = r_bank2[w_col];

  // w_ptr is the bank of the current line, which also still holds line-3.
  always_comb begin
    w_rd1 = w_b2;
    w_rd2 = w_b1;
    w_rd3 = w_b0;
    case (w_ptr)
      2'd1: begin
        w_rd1 = w_b0;
        w_rd2 = w_b2;
        w_rd3 = w_b1;
      end
      2'd2: begin
        w_rd1 = w_b1;
        w_rd2 = w_b0;
        w_rd3 = w_b2;
      end
      default: begin
        w_rd1 = w_b2;
        w_rd2 = w_b1;
        w_rd3 = w_b0;
      end
    endcase
  end

  // Read-first: the old line-3 value is captured before the overwrite lands.
  always_ff @(posedge clk) begin
    if (w_proc) begin
      r_rd1 <= w_rd1;
      r_rd2 <= w_rd2;
      r_rd3 <= w_rd3;
      case (w_ptr)
        2'd0:    r_bank0[w_col] <= s_data;
        2'd1:    r_bank1[w_col] <= s_data;
        default: r_bank2[w_col] <= s_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_col    <= '0;
      r_line   <= '0;
      r_ptr    <= 2'd0;
      r_width  <= '0;
      r_height <= '0;
      r_row0   <= '0;
      r_m1     <= 1'b0;
      r_m2     <= 1'b0;
      r_m3     <= 1'b0;
      r_shift  <= 1'b0;
      r_winv   <= 1'b0;
      r_winx   <= '0;
      r_winy   <= '0;
      r_fdone  <= 1'b0;
      r_cerr   <= 1'b0;
    end else begin
      r_shift <= w_proc;
      r_winv  <= w_proc && (w_line >= 16'd3) && (w_col >= ADDR_WIDTH'(3));
      r_fdone <= w_proc & w_eof;
      r_cerr  <= w_reject;
      r_ready <= 1'b1;

      if (w_proc) begin
        r_row0 <= s_data;
        r_m1   <= (w_line >= 16'd1);
        r_m2   <= (w_line >= 16'd2);
        r_m3   <= (w_line >= 16'd3);
        r_winx <= w_col;
        r_winy <= w_line;
      end

      if (w_start) begin
        r_width  <= cfg_width;
        r_height <= cfg_height;
      end

      if (w_reject) begin
        r_state <= S_IDLE;
        r_col   <= '0;
        r_line  <= '0;
        r_ptr   <= 2'd0;
      end else if (w_proc) begin
        if (w_eof) begin
          r_state <= S_DONE;
          r_ready <= 1'b0;
          r_col   <= '0;
          r_line  <= '0;
          r_ptr   <= 2'd0;
        end else if (w_eol) begin
          r_state <= (w_line >= 16'd2) ? S_RUN : S_FILL;
          r_col   <= '0;
          r_line  <= w_line + 16'd1;
          r_ptr   <= w_ptr_nxt;
        end else begin
          r_state <= (w_line >= 16'd3) ? S_RUN : S_FILL;
          r_col   <= w_col + ADDR_WIDTH'(1);
          r_line  <= w_line;
          r_ptr   <= w_ptr;
        end
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign s_ready      = r_ready;
  assign row0_out     = r_row0;
  assign row1_out     = r_m1 ? r_rd1 : '0;
  assign row2_out     = r_m2 ? r_rd2 : '0;
  assign row3_out     = r_m3 ? r_rd3 : '0;
  assign shift_window = r_shift;
  assign win_valid    = r_winv;
  assign win_x        = r_winx;
  assign win_y        = r_winy;
  assign frame_done   = r_fdone;
  assign cfg_err      = r_cerr;

endmodule

// File: tb/tb_bicubic_window_feeder.sv
// Self-checking bench: whole-frame image model predicts every output each cycle,
// with literal pins and per-scenario pulse counts.
module tb_bicubic_window_feeder;
  localparam int DW   = 8;
  localparam int MAXW = 1024;
  localparam int AW   = 10;
  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW:0]   cfg_width = '0;
  logic [15:0]   cfg_height = '0;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [DW-1:0] row0_out, row1_out, row2_out, row3_out;
  logic          shift_window, win_valid, frame_done, cfg_err;
  logic [AW-1:0] win_x;
  logic [15:0]   win_y;

  bicubic_window_feeder #(.DATA_WIDTH(DW), .MAX_WIDTH(MAXW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .row0_out(row0_out), .row1_out(row1_out), .row2_out(row2_out), .row3_out(row3_out),
    .shift_window(shift_window), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: the frame is kept as a plain image, rows are looked up by line.
  logic [DW-1:0] mdl_img [0:15][0:1023];
  int            m_state = M_IDLE;
  int            mx = 0, my = 0, mW = 0, mH = 0;
  bit            acc, do_emit;
  bit            e_ready = 0, e_shift = 0, e_winv = 0, e_fdone = 0, e_cerr = 0;
  logic [DW-1:0] e_row [4] = '{default: '0};
  logic [AW-1:0] e_winx = '0;
  logic [15:0]   e_winy = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_ready = 0; e_shift = 0; e_winv = 0; e_fdone = 0; e_cerr = 0;
      e_winx = '0; e_winy = '0;
      for (int k = 0; k < 4; k++) e_row[k] = '0;
      m_state = M_IDLE; mx = 0; my = 0;
    end else begin
      e_shift = 0; e_winv = 0; e_fdone = 0; e_cerr = 0;
      do_emit = 0;
      acc = s_valid && e_ready;
      if (m_state == M_DONE) begin
        m_state = M_IDLE;
        e_ready = 1;
      end else begin
        e_ready = 1;
        if (acc && s_sof) begin
          if (int'(cfg_width) < 4 || int'(cfg_width) > MAXW || int'(cfg_height) < 4) begin
            e_cerr = 1;
            m_state = M_IDLE;
          end else begin
            mW = int'(cfg_width); mH = int'(cfg_height);
            mx = 0; my = 0; m_state = M_ACT; do_emit = 1;
          end
        end else if (acc && m_state == M_ACT) begin
          do_emit = 1;
        end
      end
      if (do_emit) begin
        mdl_img[my][mx] = s_data;
        e_shift  = 1;
        e_row[0] = s_data;
        for (int k = 1; k < 4; k++) e_row[k] = (my >= k) ? mdl_img[my-k][mx] : '0;
        e_winv = (my >= 3) && (mx >= 3);
        e_winx = AW'(mx);
        e_winy = 16'(my);
        if (mx == mW - 1) begin
          mx = 0;
          if (my == mH - 1) begin
            e_fdone = 1; m_state = M_DONE; e_ready = 0;
          end else my++;
        end else mx++;
      end
    end
  end

  int n_checks = 0, n_pass = 0;
  bit chk_en = 0;
  int scen = 0, last_scen = 0;
  int cum_shift = 0, cum_winv = 0, cum_fdone = 0, cum_cerr = 0;
  int base_shift = 0, base_winv = 0, base_fdone = 0, base_cerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_counts(input int sh, input int wv, input int fd, input int ce);
    chk("cnt_shift", 32'(cum_shift - base_shift), 32'(sh));
    chk("cnt_winv",  32'(cum_winv - base_winv),   32'(wv));
    chk("cnt_fdone", 32'(cum_fdone - base_fdone), 32'(fd));
    chk("cnt_cerr",  32'(cum_cerr - base_cerr),   32'(ce));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (scen != last_scen) begin
        case (last_scen)
          1, 2, 8: chk_counts(48, 15, 1, 0);
          3:       chk_counts(0, 0, 0, 3);
          4:       chk_counts(133, 37, 2, 0);
          5:       chk_counts(36, 1, 1, 1);
          default: ;
        endcase
        base_shift = cum_shift; base_winv = cum_winv;
        base_fdone = cum_fdone; base_cerr = cum_cerr;
        last_scen = scen;
      end
      chk("s_ready",      32'(s_ready),      32'(e_ready));
      chk("shift_window", 32'(shift_window), 32'(e_shift));
      chk("win_valid",    32'(win_valid),    32'(e_winv));
      chk("frame_done",   32'(frame_done),   32'(e_fdone));
      chk("cfg_err",      32'(cfg_err),      32'(e_cerr));
      chk("row0",  32'(row0_out), 32'(e_row[0]));
      chk("row1",  32'(row1_out), 32'(e_row[1]));
      chk("row2",  32'(row2_out), 32'(e_row[2]));
      chk("row3",  32'(row3_out), 32'(e_row[3]));
      chk("win_x", 32'(win_x), 32'(e_winx));
      chk("win_y", 32'(win_y), 32'(e_winy));
      if ((scen == 1 || scen == 2 || scen == 8) && e_shift) begin
        if (e_winx == 10'd3 && e_winy == 16'd3) begin
          chk("pin33_row0", 32'(row0_out), 32'h33);
          chk("pin33_row1", 32'(row1_out), 32'h23);
          chk("pin33_row2", 32'(row2_out), 32'h13);
          chk("pin33_row3", 32'(row3_out), 32'h03);
          chk("pin33_winv", 32'(win_valid), 32'd1);
          chk("pin33_x",    32'(win_x), 32'd3);
          chk("pin33_y",    32'(win_y), 32'd3);
        end
        if (e_winx == 10'd2 && e_winy == 16'd1) begin
          chk("pin21_row0", 32'(row0_out), 32'h12);
          chk("pin21_row1", 32'(row1_out), 32'h02);
          chk("pin21_row2", 32'(row2_out), 32'h00);
          chk("pin21_row3", 32'(row3_out), 32'h00);
          chk("pin21_winv", 32'(win_valid), 32'd0);
        end
      end
      cum_shift += int'(shift_window);
      cum_winv  += int'(win_valid);
      cum_fdone += int'(frame_done);
      cum_cerr  += int'(cfg_err);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
    end
  endtask

  // Holds one pixel on the bus until the model says it is accepted.
  task automatic drive_px(input bit sof, input int w, input int h, input logic [DW-1:0] d,
                          input int prob);
    int  budget = 0;
    bit  done = 0;
    while (!done) begin
      @(negedge clk);
      s_valid    = ($urandom_range(0, 99) < prob);
      s_sof      = sof;
      s_data     = d;
      cfg_width  = sof ? (AW+1)'(w) : (AW+1)'($urandom_range(0, 2047));
      cfg_height = sof ? 16'(h) : 16'($urandom_range(0, 65535));
      if (s_valid && e_ready) done = 1;
      budget++;
      if (budget > 1000) begin
        $display("FAIL stim_timeout: pixel not accepted after %0d cycles", budget);
        $fatal(1);
      end
    end
  endtask

  task automatic send_frame(input int w, input int h, input int prob, input bit pat, input int npix);
    for (int i = 0; i < npix; i++) begin
      int x, y;
      x = i % w;
      y = i / w;
      drive_px(i == 0, w, h, pat ? DW'((y << 4) | x) : DW'($urandom), prob);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);

    scen = 1; send_frame(8, 6, 100, 1, 48); idle(5);
    scen = 2; send_frame(8, 6, 50, 1, 48);  idle(5);

    scen = 3;
    drive_px(1, 3, 6, 8'hAA, 100);
    drive_px(1, 1025, 6, 8'hBB, 100);
    drive_px(1, 8, 3, 8'hCC, 100);
    repeat (3) drive_px(0, 8, 6, DW'($urandom), 100);
    idle(5);

    scen = 4;
    send_frame(8, 6, 100, 1, 37);
    send_frame(8, 6, 100, 1, 48);
    send_frame(8, 6, 100, 1, 48);
    idle(5);

    scen = 5;
    send_frame(8, 6, 100, 0, 20);
    drive_px(1, 2, 6, 8'h5A, 100);
    repeat (2) drive_px(0, 8, 6, DW'($urandom), 100);
    send_frame(4, 4, 100, 0, 16);
    idle(5);

    scen = 6;
    for (int f = 0; f < 5; f++) begin
      int w, h;
      w = $urandom_range(4, 16);
      h = $urandom_range(4, 12);
      send_frame(w, h, $urandom_range(30, 100), 0, w * h);
      idle($urandom_range(0, 2));
    end
    idle(5);

    scen = 7;
    send_frame(8, 6, 100, 1, 29);
    @(posedge clk);
    #1 rst = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4);

    scen = 8; send_frame(8, 6, 100, 1, 48); idle(5);
    scen = 99; idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
